palette_pixel_stream: RTL and testbench

PALETTE_PIXEL_STREAM -- requirements
Module: palette_pixel_stream

---
 rtl/palette_pixel_stream.sv | 171 +++++++++++++++++
 tb/tb_palette_pixel_stream.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/palette_pixel_stream.sv
// palette_pixel_stream: streams a palette-indexed frame as packed RGB565/RGB332 beats.
// Index ROM -> palette ROM -> converted-pixel FIFO -> beat assembler -> registered output.
module palette_pixel_stream #(
    parameter int H_RES      = 96,
    parameter int V_RES      = 64,
    parameter int IDX_W      = 8,
    parameter int PPB        = 1,
    parameter int FIFO_DEPTH = 4,
    localparam int AW        = $clog2(H_RES * V_RES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              mode,
    output logic [AW-1:0]     pix_addr,
    input  logic [IDX_W-1:0]  pix_idx,
    output logic [IDX_W-1:0]  pal_addr,
    input  logic [7:0]        pal_r,
    input  logic [7:0]        pal_g,
    input  logic [7:0]        pal_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        byte_count,
    output logic [119:0]      d_out,
    output logic              sof,
    output logic              eof
);
    localparam int N  = H_RES * V_RES;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [AW-1:0]  r_addr;
    logic           r_mode;
    logic           r_v1, r_v2, r_m1, r_m2, r_f1, r_f2, r_l1, r_l2;
    logic [18:0]    r_mem [FIFO_DEPTH];
    logic [PW-1:0]  r_wp, r_rp;
    logic [CW-1:0]  r_cnt;
    logic [119:0]   r_acc_d;
    logic [3:0]     r_acc_b;
    logic [2:0]     r_acc_n;
    logic           r_acc_done, r_acc_sof, r_acc_eof;
    logic           r_ov, r_sof, r_eof;
    logic [3:0]     r_bc;
    logic [119:0]   r_d;

    logic [CW:0]    w_busy;
    logic           w_fetch, w_fmode, w_take, w_load, w_oready;
    logic           w_hm, w_hf, w_hl;
    logic [15:0]    w_hpx, w_px;
    logic [119:0]   w_ext, w_nd;
    logic [3:0]     w_nb;
    logic [2:0]     w_nn;
    logic           w_ndone, w_nsof, w_neof;

    // Fetch budget counts pixels already queued plus those still in the ROM pipeline.
    assign w_busy   = {1'b0, r_cnt} + (CW+1)'(r_v1) + (CW+1)'(r_v2);
    assign w_fetch  = enable && (w_busy < (CW+1)'(FIFO_DEPTH));
    assign w_fmode  = (r_addr == '0) ? mode : r_mode;
    assign pix_addr = r_addr;
    assign pal_addr = r_v1 ? pix_idx : '0;
    assign w_px     = r_m2 ? {8'h00, pal_r[7:5], pal_g[7:5], pal_b[7:6]}
                           : {pal_r[7:3], pal_g[7:2], pal_b[7:3]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr <= '0;
            r_mode <= 1'b0;
            r_v1   <= 1'b0;
            r_v2   <= 1'b0;
            r_m1   <= 1'b0;
            r_m2   <= 1'b0;
            r_f1   <= 1'b0;
            r_f2   <= 1'b0;
            r_l1   <= 1'b0;
            r_l2   <= 1'b0;
        end else begin
            r_v1 <= w_fetch;
            r_m1 <= w_fmode;
            r_f1 <= (r_addr == '0);
            r_l1 <= (r_addr == AW'(N - 1));
            r_v2 <= r_v1;
            r_m2 <= r_m1;
            r_f2 <= r_f1;
            r_l2 <= r_l1;
            if (w_fetch) begin
                r_addr <= (r_addr == AW'(N - 1)) ? '0 : r_addr + 1'b1;
                r_mode <= w_fmode;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (r_v2)
            r_mem[r_wp] <= {r_m2, r_f2, r_l2, w_px};
    end

    assign {w_hm, w_hf, w_hl, w_hpx} = r_mem[r_rp];
    assign w_take   = !r_acc_done && (r_cnt != '0);
    assign w_oready = !r_ov || out_ready;

    // The head pixel may complete a beat and go straight to the output in the same cycle.
    assign w_ext   = w_hm ? {w_hpx[7:0], 112'b0} : {w_hpx, 104'b0};
    assign w_nd    = r_acc_d | (w_take ? (w_ext >> {r_acc_b, 3'b000}) : '0);
    assign w_nb    = r_acc_b + (w_take ? (w_hm ? 4'd1 : 4'd2) : 4'd0);
    assign w_nn    = r_acc_n + {2'b00, w_take};
    assign w_ndone = r_acc_done || (w_take && ((w_nn == 3'(PPB)) || w_hl));
    assign w_nsof  = r_acc_sof || (w_take && w_hf);
    assign w_neof  = r_acc_eof || (w_take && w_hl);
    assign w_load  = w_ndone && w_oready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (r_v2)
                r_wp <= (r_wp == PW'(FIFO_DEPTH - 1)) ? '0 : r_wp + 1'b1;
            if (w_take)
                r_rp <= (r_rp == PW'(FIFO_DEPTH - 1)) ? '0 : r_rp + 1'b1;
            r_cnt <= r_cnt + CW'(r_v2) - CW'(w_take);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc_d    <= '0;
            r_acc_b    <= '0;
            r_acc_n    <= '0;
            r_acc_done <= 1'b0;
            r_acc_sof  <= 1'b0;
            r_acc_eof  <= 1'b0;
        end else if (w_load) begin
            r_acc_d    <= '0;
            r_acc_b    <= '0;
            r_acc_n    <= '0;
            r_acc_done <= 1'b0;
            r_acc_sof  <= 1'b0;
            r_acc_eof  <= 1'b0;
        end else begin
            r_acc_d    <= w_nd;
            r_acc_b    <= w_nb;
            r_acc_n    <= w_nn;
            r_acc_done <= w_ndone;
            r_acc_sof  <= w_nsof;
            r_acc_eof  <= w_neof;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ov  <= 1'b0;
            r_d   <= '0;
            r_bc  <= '0;
            r_sof <= 1'b0;
            r_eof <= 1'b0;
        end else if (w_oready) begin
            r_ov  <= w_load;
            r_d   <= w_load ? w_nd : '0;
            r_bc  <= w_load ? w_nb : '0;
            r_sof <= w_load && w_nsof;
            r_eof <= w_load && w_neof;
        end
    end

    assign out_valid  = r_ov;
    assign d_out      = r_d;
    assign byte_count = r_bc;
    assign sof        = r_sof;
    assign eof        = r_eof;
endmodule

// File: tb/tb_palette_pixel_stream.sv
// tb_palette_pixel_stream: three instances (PPB=1,7,4) fed by shared controls, beats checked
// against per-instance scoreboards built from the conversion and packing rules.
module tb_palette_pixel_stream;
    localparam int N = 96 * 64;

    typedef struct {
        logic [119:0] d;
        logic [3:0]   bc;
        logic         s;
        logic         e;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enable = 1'b0;
    logic mode = 1'b0;
    logic out_ready = 1'b1;
    always #5 clk = ~clk;

    logic [12:0]  pa [3];
    logic [7:0]   pidx [3];
    logic [7:0]   paddr [3];
    logic [7:0]   pal [3];
    logic         ov [3];
    logic         sof [3];
    logic         eof [3];
    logic [3:0]   bc [3];
    logic [119:0] dq [3];

    palette_pixel_stream #(.PPB(1)) u0 (
        .clk(clk), .rst(rst), .enable(enable), .mode(mode), .pix_addr(pa[0]), .pix_idx(pidx[0]),
        .pal_addr(paddr[0]), .pal_r(pal[0]), .pal_g(pal[0]), .pal_b(pal[0]), .out_valid(ov[0]),
        .out_ready(out_ready), .byte_count(bc[0]), .d_out(dq[0]), .sof(sof[0]), .eof(eof[0]));
    palette_pixel_stream #(.PPB(7)) u1 (
        .clk(clk), .rst(rst), .enable(enable), .mode(mode), .pix_addr(pa[1]), .pix_idx(pidx[1]),
        .pal_addr(paddr[1]), .pal_r(pal[1]), .pal_g(pal[1]), .pal_b(pal[1]), .out_valid(ov[1]),
        .out_ready(out_ready), .byte_count(bc[1]), .d_out(dq[1]), .sof(sof[1]), .eof(eof[1]));
    palette_pixel_stream #(.PPB(4)) u2 (
        .clk(clk), .rst(rst), .enable(enable), .mode(mode), .pix_addr(pa[2]), .pix_idx(pidx[2]),
        .pal_addr(paddr[2]), .pal_r(pal[2]), .pal_g(pal[2]), .pal_b(pal[2]), .out_valid(ov[2]),
        .out_ready(out_ready), .byte_count(bc[2]), .d_out(dq[2]), .sof(sof[2]), .eof(eof[2]));

    // Index ROM holds address[7:0]; palette returns r=g=b=index.
    always @(posedge clk)
        for (int k = 0; k < 3; k++) begin
            pidx[k] <= pa[k][7:0];
            pal[k]  <= paddr[k];
        end

    beat_t sb0[$], sb1[$], sb2[$];
    int checks = 0;
    int errors = 0;
    int n14 = 0;
    logic [3:0] lastbc = 4'd0;
    bit f1done = 1'b0;

    task automatic gen_frame(input int k, input int ppb, input bit m);
        beat_t b;
        logic [7:0] i;
        for (int p = 0; p < N; p += ppb) begin
            int n;
            n = (N - p < ppb) ? N - p : ppb;
            b.d = '0;
            for (int j = 0; j < n; j++) begin
                i = 8'(p + j);
                if (m) b.d[119-8*j -: 8] = {i[7:5], i[7:5], i[7:6]};
                else   b.d[119-16*j -: 16] = {i[7:3], i[7:2], i[7:3]};
            end
            b.bc = 4'(m ? n : 2 * n);
            b.s  = (p == 0);
            b.e  = (p + n == N);
            case (k)
                0: sb0.push_back(b);
                1: sb1.push_back(b);
                default: sb2.push_back(b);
            endcase
        end
    endtask

    // One clock; every beat accepted at that edge is popped from its scoreboard and compared.
    task automatic step();
        beat_t g, e;
        int sz;
        for (int k = 0; k < 3; k++)
            if (ov[k] && out_ready) begin
                g.d = dq[k]; g.bc = bc[k]; g.s = sof[k]; g.e = eof[k];
                sz = (k == 0) ? sb0.size() : (k == 1) ? sb1.size() : sb2.size();
                checks++;
                if (sz == 0) begin
                    errors++;
                    $display("FAIL beat_unexpected inst%0d got d=%h bc=%0d", k, g.d, g.bc);
                end else begin
                    case (k)
                        0: e = sb0.pop_front();
                        1: e = sb1.pop_front();
                        default: e = sb2.pop_front();
                    endcase
                    if (g.d !== e.d || g.bc !== e.bc || g.s !== e.s || g.e !== e.e) begin
                        errors++;
                        $display("FAIL beat inst%0d got d=%h bc=%0d sof=%b eof=%b expected d=%h bc=%0d sof=%b eof=%b",
                                 k, g.d, g.bc, g.s, g.e, e.d, e.bc, e.s, e.e);
                    end
                end
                if (k == 1 && !f1done) begin
                    if (eof[1]) begin
                        f1done = 1'b1;
                        lastbc = bc[1];
                    end else if (bc[1] == 4'd14) n14++;
                end
            end
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (ov[k] !== 1'b0 || sof[k] !== 1'b0 || eof[k] !== 1'b0 || bc[k] !== 4'd0 ||
                dq[k] !== '0 || pa[k] !== '0 || paddr[k] !== '0) begin
                errors++;
                $display("FAIL %s inst%0d got ov=%b sof=%b eof=%b bc=%0d d=%h pix_addr=%0d pal_addr=%0d expected all 0",
                         tag, k, ov[k], sof[k], eof[k], bc[k], dq[k], pa[k], paddr[k]);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        check_zero("reset_state");
        rst = 1'b0;
    endtask

    task automatic test_first_beat();
        int n = 0;
        mode = 1'b0;
        enable = 1'b1;
        for (int k = 0; k < 3; k++) begin
            int ppb;
            ppb = (k == 0) ? 1 : (k == 1) ? 7 : 4;
            gen_frame(k, ppb, 1'b0);
            gen_frame(k, ppb, 1'b1);
            gen_frame(k, ppb, 1'b1);
        end
        while (!ov[0] && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL first_latency got %0d cycles expected 4", n);
        end
        checks++;
        if (bc[0] !== 4'd2 || sof[0] !== 1'b1) begin
            errors++;
            $display("FAIL first_beat got bc=%0d sof=%b expected bc=2 sof=1", bc[0], sof[0]);
        end
    endtask

    task automatic test_mode_switch();
        int n = 0;
        while (pa[0] < 13'd100 && n < 1000) begin
            step();
            n++;
        end
        checks++;
        if (pa[0] < 13'd100) begin
            errors++;
            $display("FAIL mode_switch_wait got pix_addr=%0d expected >=100", pa[0]);
        end
        mode = 1'b1;
    endtask

    task automatic test_stall();
        logic [119:0] sd [3];
        logic [12:0] sa;
        int n = 0;
        while (pa[0] < 13'd1000 && n < 2000) begin
            step();
            n++;
        end
        out_ready = 1'b0;
        repeat (12) step();
        for (int k = 0; k < 3; k++) sd[k] = dq[k];
        sa = pa[0];
        repeat (8) step();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (ov[k] !== 1'b1 || dq[k] !== sd[k]) begin
                errors++;
                $display("FAIL stall_hold inst%0d got ov=%b d=%h expected ov=1 d=%h", k, ov[k], dq[k], sd[k]);
            end
        end
        checks++;
        if (pa[0] !== sa) begin
            errors++;
            $display("FAIL stall_fetch got pix_addr=%0d expected %0d", pa[0], sa);
        end
        out_ready = 1'b1;
    endtask

    task automatic test_enable_drop();
        logic [12:0] sa [3];
        int n = 0;
        while (pa[2][1:0] != 2'd2 && n < 20) begin
            step();
            n++;
        end
        enable = 1'b0;
        repeat (15) step();
        for (int k = 0; k < 3; k++) sa[k] = pa[k];
        repeat (5) step();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (pa[k] !== sa[k]) begin
                errors++;
                $display("FAIL enable_hold inst%0d got pix_addr=%0d expected %0d", k, pa[k], sa[k]);
            end
        end
        checks++;
        if (ov[2] !== 1'b0) begin
            errors++;
            $display("FAIL partial_withheld got ov=%b expected 0", ov[2]);
        end
        enable = 1'b1;
    endtask

    task automatic test_full_frame();
        int n = 0;
        while (!(sb0.size() <= N - 10 && sb1.size() <= 876 && sb2.size() <= 1533) && n < 40000) begin
            step();
            n++;
        end
        checks++;
        if (n >= 40000) begin
            errors++;
            $display("FAIL drain_timeout got sizes %0d %0d %0d", sb0.size(), sb1.size(), sb2.size());
        end
        checks++;
        if (!f1done || n14 != 877 || lastbc !== 4'd10) begin
            errors++;
            $display("FAIL ppb7_frame got full=%0d last_bc=%0d eof_seen=%b expected full=877 last_bc=10 eof_seen=1",
                     n14, lastbc, f1done);
        end
    endtask

    task automatic test_reset_midframe();
        int n = 0;
        while (!ov[0] && n < 20) begin
            step();
            n++;
        end
        rst = 1'b1;
        #1;
        check_zero("reset_async");
        mode = 1'b0;
        sb0.delete();
        sb1.delete();
        sb2.delete();
        gen_frame(0, 1, 1'b0);
        gen_frame(1, 7, 1'b0);
        gen_frame(2, 4, 1'b0);
        step();
        step();
        rst = 1'b0;
        n = 0;
        while (!ov[0] && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (ov[0] !== 1'b1 || sof[0] !== 1'b1 || dq[0][119:104] !== 16'h0000) begin
            errors++;
            $display("FAIL post_reset_beat got ov=%b sof=%b px=%h expected ov=1 sof=1 px=0000",
                     ov[0], sof[0], dq[0][119:104]);
        end
        repeat (300) step();
    endtask

    initial begin
        test_reset();
        test_first_beat();
        test_mode_switch();
        test_stall();
        test_enable_drop();
        test_full_frame();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
